// File: rtl/board_led_ctrl.sv
// Board LED controller: button synchronise/debounce, user LED override and
// RGB LED brightness gating for the Arty A7 + Ibex Demo System.
// Optional feature macro: BOARD_LED_CTRL_PWM_EN enables the shared PWM
// brightness scheduler on the RGB lines; without it the RGB lines are a plain
// registered copy of the GPO bits and brightness_i is ignored.
module board_led_ctrl #(
  parameter int unsigned DebounceCycles = 50000,
  parameter int unsigned PwmWidth       = 8
) (
  input  logic                clk_sys_i,
  input  logic                rst_sys_i,
  input  logic [3:0]          btn_i,
  input  logic [3:0]          gp_led_i,
  input  logic [11:0]         gp_rgb_i,
  input  logic [PwmWidth-1:0] brightness_i,
  output logic [3:0]          led_o,
  output logic [11:0]         rgb_led_o,
  output logic [3:0]          btn_o,
  output logic [3:0]          btn_press_o,
  output logic [3:0]          btn_release_o
);

  localparam int unsigned NumBtn = 4;
  localparam int unsigned CntW   = $clog2(DebounceCycles + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(DebounceCycles - 1);

  typedef enum logic {
    StStable = 1'b0,
    StCheck  = 1'b1
  } db_state_e;

  logic [NumBtn-1:0] sync1_q;
  logic [NumBtn-1:0] sync2_q;
  db_state_e         state_q [NumBtn];
  logic [CntW-1:0]   cnt_q   [NumBtn];
  logic [NumBtn-1:0] btn_q;
  logic [NumBtn-1:0] press_q;
  logic [NumBtn-1:0] release_q;
  logic [3:0]        led_q;
  logic [11:0]       rgb_q;

  // Two-flop synchroniser for the asynchronous button inputs
  always_ff @(posedge clk_sys_i) begin
    if (rst_sys_i) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
    end
  end

  // Per-button debounce FSMs; a level must disagree with btn_q continuously
  // through the whole CHECK count before it is accepted
  always_ff @(posedge clk_sys_i) begin
    if (rst_sys_i) begin
      for (int i = 0; i < NumBtn; i++) begin
        state_q[i] <= StStable;
        cnt_q[i]   <= '0;
      end
      btn_q     <= '0;
      press_q   <= '0;
      release_q <= '0;
    end else begin
      press_q   <= '0;
      release_q <= '0;
      for (int i = 0; i < NumBtn; i++) begin
        unique case (state_q[i])
          StStable: begin
            if (sync2_q[i] != btn_q[i]) begin
              state_q[i] <= StCheck;
              cnt_q[i]   <= '0;
            end
          end
          StCheck: begin
            if (sync2_q[i] == btn_q[i]) begin
              // Glitch: drop the partial count
              state_q[i] <= StStable;
            end else if (cnt_q[i] == CntLast) begin
              btn_q[i]     <= sync2_q[i];
              press_q[i]   <= sync2_q[i];
              release_q[i] <= ~sync2_q[i];
              state_q[i]   <= StStable;
            end else begin
              cnt_q[i] <= cnt_q[i] + CntW'(1);
            end
          end
          default: state_q[i] <= StStable;
        endcase
      end
    end
  end

  // User LED arbitration: a held button forces its LED off
  always_ff @(posedge clk_sys_i) begin
    if (rst_sys_i) begin
      led_q <= '0;
    end else begin
      led_q <= gp_led_i & ~btn_q;
    end
  end

`ifdef BOARD_LED_CTRL_PWM_EN
  logic [PwmWidth-1:0] pwm_cnt_q;
  logic                pwm_en;

  assign pwm_en = (pwm_cnt_q < brightness_i);

  // Free-running PWM phase shared by all RGB lines, gated RGB register
  always_ff @(posedge clk_sys_i) begin
    if (rst_sys_i) begin
      pwm_cnt_q <= '0;
      rgb_q     <= '0;
    end else begin
      pwm_cnt_q <= pwm_cnt_q + PwmWidth'(1);
      rgb_q     <= gp_rgb_i & {12{pwm_en}};
    end
  end
`else
  logic unused_brightness;
  assign unused_brightness = ^brightness_i;

  // RGB lines are a straight registered copy of the GPO bits
  always_ff @(posedge clk_sys_i) begin
    if (rst_sys_i) begin
      rgb_q <= '0;
    end else begin
      rgb_q <= gp_rgb_i;
    end
  end
`endif

  assign led_o         = led_q;
  assign rgb_led_o     = rgb_q;
  assign btn_o         = btn_q;
  assign btn_press_o   = press_q;
  assign btn_release_o = release_q;

endmodule
